bcd_down_counter: RTL

Synchronous multi-digit BCD (decade) down counter. It is the count-down counterpart to the team's decade up counter.
- Loads a BCD start value and decrements once per enabled cycle.
- Flags terminal zero and pulses `done` on reaching it.
- Optionally auto-reloads for periodic timing.
- Single clock domain, no ripple clocking; feeds timer/display logic downstream.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_down_digit.sv | 26 ++
 rtl/bcd_down_counter.sv | 68 ++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load-time digit clamp.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the down counter: load, or decrement on borrow_in, wrapping 0 -> 9.
// borrow_out asks the next digit to decrement when this one wraps.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  assign borrow_out = borrow_in & (digit == BCD_ZERO);

  always_ff @(posedge clk) begin
    if (rst)
      digit <= BCD_ZERO;
    else if (load)
      digit <= load_digit;
    else if (borrow_in)
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down counter with terminal-zero flag, done pulse
// and optional auto-reload of the last loaded start value.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    load_clamped;
  logic [W-1:0]    reload_val;
  logic [W-1:0]    digit_load_val;
  logic [DIGITS:0] borrow;
  logic            dec;
  logic            reload_now;
  logic            digit_load;
  logic            borrow_unused;

  assign zero       = (q == '0);
  assign dec        = en & ~load & ~zero;
  // At zero with auto-reload, the digits take the stored start value instead of borrowing.
  assign reload_now = AUTO_RELOAD & en & ~load & zero;
  assign digit_load = load | reload_now;
  assign digit_load_val = load ? load_clamped : reload_val;

  assign borrow[0]     = dec;
  assign borrow_unused = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[4*g +: 4] = bcd_clamp(load_val[4*g +: 4]);

    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (digit_load),
      .load_digit (digit_load_val[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit      (q[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      reload_val <= '0;
    else if (load)
      reload_val <= load_clamped;
  end

  always_ff @(posedge clk) begin
    if (rst)
      done <= 1'b0;
    else
      done <= dec && (q == W'(1));
  end

endmodule
